// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with a Wishbone CSR/DATA slave.
// Drives the shared clock/data lines open-drain (pull-low enables only) and raises one IRQ per completed frame.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 6000,
    parameter int unsigned REQ_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 750000,
    parameter int unsigned FILT        = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        busy
);

    localparam int unsigned FCW = $clog2(FILT + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT - 1);
    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] REQ_LAST = 20'(REQ_CYC - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] tmr, tmr_nxt;
    logic [3:0]  bitcnt, bitcnt_nxt;
    logic        drv, drv_nxt;
    logic        edge_clr, frame_done, frame_to, ack_take;

    logic [1:0]     sync1, sync2, filt;
    logic [FCW-1:0] fcnt [2];
    logic           clk_f, data_f, clk_prev, clk_fall;

    logic       ready, ie, err, nak, ready_d, ie_d, irq_pend, irq_set;
    logic [7:0] tx_byte;
    logic       acc, wr_csr, wr_data, start;
    logic [15:0] csr_rd;

    logic unused_inputs;
    assign unused_inputs = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1]};

    // Line conditioning: 2-FF synchroniser, then a level is accepted only after FILT differing samples.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync1 <= '1;
            sync2 <= '1;
            filt  <= '1;
            for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= {ps2_data, ps2_clk};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign clk_f  = filt[0];
    assign data_f = filt[1];

    // Cleared on INHIBIT entry so a fall is only recognised after the device has shown clk high.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) clk_prev <= 1'b1;
        else             clk_prev <= edge_clr ? 1'b0 : clk_f;
    end

    assign clk_fall = clk_prev & ~clk_f;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state  <= S_IDLE;
            tmr    <= '0;
            bitcnt <= '0;
            drv    <= 1'b0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            bitcnt <= bitcnt_nxt;
            drv    <= drv_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr + 20'd1;
        bitcnt_nxt = bitcnt;
        drv_nxt    = drv;
        edge_clr   = 1'b0;
        frame_done = 1'b0;
        frame_to   = 1'b0;
        ack_take   = 1'b0;
        unique case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (start) begin
                    state_nxt = S_INHIBIT;
                    edge_clr  = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (tmr == INH_LAST) begin
                    state_nxt = S_REQ;
                    tmr_nxt   = '0;
                end
            end
            S_REQ: begin
                if (tmr == REQ_LAST) begin
                    state_nxt  = S_SEND;
                    tmr_nxt    = '0;
                    bitcnt_nxt = '0;
                    drv_nxt    = 1'b1;
                end
            end
            S_SEND: begin
                if (clk_fall) begin
                    bitcnt_nxt = bitcnt + 4'd1;
                    if (bitcnt < 4'd8) begin
                        drv_nxt = ~tx_byte[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        // odd parity bit is ~^byte; pull low when it is 0
                        drv_nxt = ^tx_byte;
                    end else begin
                        drv_nxt   = 1'b0;
                        state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    ack_take  = 1'b1;
                    state_nxt = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                tmr_nxt = '0;
                if (clk_f && data_f) begin
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if ((state == S_SEND || state == S_ACK) && tmr == TO_LAST) begin
            state_nxt = S_IDLE;
            drv_nxt   = 1'b0;
            frame_to  = 1'b1;
            ack_take  = 1'b0;
        end
    end

    assign busy        = (state != S_IDLE);
    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
    assign ps2_data_oe = (state == S_REQ) || ((state == S_SEND || state == S_ACK) && drv);

    assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_csr  = acc & wb_we_i & ~wb_adr_i[1] & wb_sel_i[0];
    assign wr_data = acc & wb_we_i &  wb_adr_i[1] & wb_sel_i[0];
    assign start   = wr_data & ready;
    assign csr_rd  = {err, nak, 6'b0, ready, ie, 6'b0};

    assign irq_set = (ready & ~ready_d & ie) | (ie & ~ie_d & ready);
    assign irq     = irq_pend;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ie       <= 1'b0;
            ready    <= 1'b1;
            err      <= 1'b0;
            nak      <= 1'b0;
            tx_byte  <= '0;
            ready_d  <= 1'b1;
            ie_d     <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            ready_d  <= ready;
            ie_d     <= ie;
            if (acc && !wb_we_i) wb_dat_o <= wb_adr_i[1] ? {8'h00, tx_byte} : csr_rd;
            if (wr_csr) ie <= wb_dat_i[6];
            if (start) begin
                tx_byte <= wb_dat_i[7:0];
                err     <= 1'b0;
                nak     <= 1'b0;
                ready   <= 1'b0;
            end
            if (ack_take)   nak   <= data_f;
            if (frame_done) ready <= 1'b1;
            if (frame_to) begin
                err   <= 1'b1;
                ready <= 1'b1;
            end
            // a new event outranks a simultaneous iack
            if (irq_set)          irq_pend <= 1'b1;
            else if (iack || !ie) irq_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: Wishbone register access plus a simple PS/2 device model on the open-drain lines.
module tb_ps2_host_tx;

    localparam int unsigned HALF = 30;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic [15:0] wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic        irq;
    logic        iack = 1'b0;
    logic        ps2_clk, ps2_data;
    logic        ps2_clk_oe, ps2_data_oe, busy;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_host_tx #(
        .INHIBIT_CYC(100),
        .REQ_CYC(4),
        .TIMEOUT_CYC(1000),
        .FILT(8)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i),
        .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o),
        .irq(irq),
        .iack(iack),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy)
    );

    always #10 wb_clk_i = ~wb_clk_i;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, output logic [15:0] rdat);
        int unsigned n;
        logic got;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        got = 1'b0; n = 0; rdat = '0;
        while (!got && n < 20) begin
            @(negedge wb_clk_i);
            n++;
            if (wb_ack_o) begin
                got  = 1'b1;
                rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) check_eq("wb_ack_bound", {31'b0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [15:0] adr, input logic [15:0] exp);
        logic [15:0] r;
        wb_xfer(1'b0, adr, 16'h0000, 2'b11, r);
        check_eq(tag, {16'b0, r}, {16'b0, exp});
    endtask

    task automatic wait_clk_release();
        int unsigned n = 0;
        while (ps2_clk_oe && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (ps2_clk_oe) check_eq("clk_release_bound", {31'b0, ps2_clk_oe}, 32'd0);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (busy) check_eq("idle_bound", {31'b0, busy}, 32'd0);
    endtask

    // bits = {stop, parity, d7..d0, start} as the device samples them
    task automatic dev_frame(input int npulses, input bit ack_low, output logic [10:0] bits);
        bits = '0;
        repeat (20) @(negedge wb_clk_i);
        bits[0] = ps2_data;
        for (int k = 0; k < npulses; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge wb_clk_i);
            if (k < 10) bits[k+1] = ps2_data;
            dev_clk_low = 1'b0;
            if (k == 9 && ack_low) dev_data_low = 1'b1;
            repeat (HALF) @(negedge wb_clk_i);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic pulse_iack();
        @(negedge wb_clk_i);
        iack = 1'b1;
        @(negedge wb_clk_i);
        iack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int unsigned c_clk, c_dat, n;

        repeat (3) @(negedge wb_clk_i);
        check_eq("reset_outputs",
                 {11'b0, wb_ack_o, irq, ps2_clk_oe, ps2_data_oe, busy, wb_dat_o}, 32'd0);
        wb_rst_n_i = 1'b1;
        rd_check("reset_csr", 16'h0000, 16'h0080);
        rd_check("reset_data", 16'h0002, 16'h0000);

        // Frame 0xED with cycle-exact inhibit/request window
        wb_write(16'h0002, 16'h00ED, 2'b01);
        c_clk = 0; c_dat = 0; n = 0;
        while (ps2_clk_oe && n < 5000) begin
            c_clk++;
            if (ps2_data_oe) c_dat++;
            @(negedge wb_clk_i);
            n++;
        end
        check_eq("inhibit_cycles", c_clk, 32'd104);
        check_eq("req_cycles", c_dat, 32'd4);
        check_eq("send_busy_start", {30'b0, busy, ps2_data_oe}, 32'd3);
        rd_check("busy_csr", 16'h0000, 16'h0000);
        dev_frame(11, 1'b1, bits);
        check_eq("frame_ed", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'hED, 1'b0});
        wait_idle();
        rd_check("ed_csr", 16'h0000, 16'h0080);
        rd_check("ed_data", 16'h0002, 16'h00ED);
        check_eq("ed_irq_off", {31'b0, irq}, 32'd0);

        // Device leaves ACK high -> NAK; next write clears it
        wb_write(16'h0002, 16'h00F4, 2'b01);
        wait_clk_release();
        dev_frame(11, 1'b0, bits);
        check_eq("frame_f4", {21'b0, bits}, {21'b0, 1'b1, 1'b0, 8'hF4, 1'b0});
        wait_idle();
        rd_check("nak_csr", 16'h0000, 16'h4080);
        wb_write(16'h0002, 16'h00ED, 2'b01);
        rd_check("nak_cleared_csr", 16'h0000, 16'h0000);
        wait_clk_release();
        dev_frame(11, 1'b1, bits);
        check_eq("frame_ed_again", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'hED, 1'b0});
        wait_idle();
        rd_check("ack_csr", 16'h0000, 16'h0080);

        // Device silent -> timeout exactly 1000 cycles after clk release
        wb_write(16'h0002, 16'h0055, 2'b01);
        wait_clk_release();
        n = 0;
        while (busy && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check_eq("timeout_cycles", n, 32'd1000);
        check_eq("timeout_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rd_check("timeout_csr", 16'h0000, 16'h8080);

        // Interrupts
        wb_write(16'h0000, 16'h0040, 2'b01);
        repeat (3) @(negedge wb_clk_i);
        check_eq("irq_ie_rise", {31'b0, irq}, 32'd1);
        pulse_iack();
        check_eq("irq_iack_clr", {31'b0, irq}, 32'd0);
        wb_write(16'h0002, 16'h00FF, 2'b01);
        wb_write(16'h0002, 16'h0012, 2'b01);
        check_eq("irq_busy_off", {31'b0, irq}, 32'd0);
        rd_check("busy_write_ignored", 16'h0002, 16'h00FF);
        rd_check("busy_ie_csr", 16'h0000, 16'h0040);
        wait_clk_release();
        dev_frame(11, 1'b1, bits);
        check_eq("frame_ff", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'hFF, 1'b0});
        wait_idle();
        repeat (2) @(negedge wb_clk_i);
        check_eq("irq_ready_rise", {31'b0, irq}, 32'd1);
        rd_check("ff_csr", 16'h0000, 16'h00C0);
        pulse_iack();
        check_eq("irq_iack_clr2", {31'b0, irq}, 32'd0);
        wb_write(16'h0000, 16'h0000, 2'b01);
        wb_write(16'h0000, 16'h0040, 2'b01);
        repeat (3) @(negedge wb_clk_i);
        check_eq("irq_ie_rise2", {31'b0, irq}, 32'd1);
        wb_write(16'h0000, 16'h0000, 2'b01);
        repeat (2) @(negedge wb_clk_i);
        check_eq("irq_ie_clr", {31'b0, irq}, 32'd0);

        // Odd-byte-only DATA write is ignored
        wb_write(16'h0002, 16'h1234, 2'b10);
        repeat (2) @(negedge wb_clk_i);
        check_eq("odd_sel_idle", {31'b0, busy}, 32'd0);
        rd_check("odd_sel_data", 16'h0002, 16'h00FF);

        // Reset mid-frame while data bit 4 (0 -> pulled low) is on the line
        wb_write(16'h0002, 16'h00ED, 2'b01);
        wait_clk_release();
        dev_frame(5, 1'b0, bits);
        check_eq("mid_frame_drive", {30'b0, busy, ps2_data_oe}, 32'd3);
        #3 wb_rst_n_i = 1'b0;
        #1 check_eq("mid_reset_release", {29'b0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        rd_check("post_reset_csr", 16'h0000, 16'h0080);
        rd_check("post_reset_data", 16'h0002, 16'h0000);

        repeat (5) @(negedge wb_clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
